// File: rtl/imm_ext_shift_unit.sv
// imm_ext_shift_unit
// Multi-cycle immediate extender/shifter for the decode stage. An accepted
// immediate is zero-, sign- or ones-extended to DATA_W bits. It is then
// left-shifted by up to STEP bits per cycle until the requested amount is
// consumed. The result is offered on a valid/ready handshake. Only one
// request is in flight at a time.
module imm_ext_shift_unit #(
  parameter int IMM_W   = 16,
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5,
  parameter int STEP    = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [IMM_W-1:0]   imm,
  input  logic [1:0]         ext_op,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  ext_imm,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [1:0] OP_ZERO = 2'b00;
  localparam logic [1:0] OP_SIGN = 2'b01;
  localparam logic [1:0] OP_ONES = 2'b10;

  state_t             state;
  logic [DATA_W-1:0]  acc;
  logic [SHAMT_W-1:0] rem;

  logic [DATA_W-1:0]  zero_ext;
  logic [DATA_W-1:0]  fill_mask;
  logic [DATA_W-1:0]  ext_value;
  logic [SHAMT_W-1:0] step_k;
  logic [SHAMT_W-1:0] rem_after;

  // Extend the raw immediate; fill_mask covers the bits above IMM_W and is
  // all-zero when IMM_W == DATA_W, which makes every extension the identity.
  always_comb begin
    zero_ext  = DATA_W'(imm);
    fill_mask = ~(DATA_W'({IMM_W{1'b1}}));
    ext_value = '0;
    case (ext_op)
      OP_ZERO: ext_value = zero_ext;
      OP_SIGN: ext_value = imm[IMM_W-1] ? (zero_ext | fill_mask) : zero_ext;
      OP_ONES: ext_value = zero_ext | fill_mask;
      default: ext_value = '0;
    endcase
  end

  // Bits to shift this cycle: STEP, or whatever remains if that is smaller.
  always_comb begin
    if (32'(rem) > STEP) begin
      step_k = SHAMT_W'(STEP);
    end else begin
      step_k = rem;
    end
    rem_after = rem - step_k;
  end

  // Control FSM and datapath registers; flush aborts back to an empty IDLE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      acc   <= '0;
      rem   <= '0;
    end else if (flush) begin
      state <= IDLE;
      acc   <= '0;
      rem   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            acc   <= ext_value;
            rem   <= shamt;
            state <= (shamt != '0) ? SHIFT : DONE;
          end
        end
        SHIFT: begin
          acc <= acc << step_k;
          rem <= rem_after;
          if (rem_after == '0) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Status outputs decode straight from the state register, so reset clears them at once.
  always_comb begin
    in_ready  = (state == IDLE);
    busy      = (state != IDLE);
    out_valid = (state == DONE);
    ext_imm   = acc;
  end

endmodule

// File: tb/tb_imm_ext_shift_unit.sv
// tb_imm_ext_shift_unit
// Scoreboard bench: stimulus pushes the hand-computed result and the cycle
// in which out_valid should first rise. A separate monitor pops and compares
// whenever the unit presents a result.
module tb_imm_ext_shift_unit;

  localparam int IMM_W   = 16;
  localparam int DATA_W  = 32;
  localparam int SHAMT_W = 5;
  localparam int STEP    = 4;

  typedef struct {
    logic [DATA_W-1:0] val;
    int                cyc;
  } exp_t;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               flush = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [IMM_W-1:0]   imm = '0;
  logic [1:0]         ext_op = 2'b00;
  logic [SHAMT_W-1:0] shamt = '0;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic [DATA_W-1:0]  ext_imm;
  logic               busy;

  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  logic [DATA_W-1:0] held;
  bit   holding = 1'b0;

  imm_ext_shift_unit #(
    .IMM_W(IMM_W), .DATA_W(DATA_W), .SHAMT_W(SHAMT_W), .STEP(STEP)
  ) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .imm(imm), .ext_op(ext_op), .shamt(shamt),
    .out_valid(out_valid), .out_ready(out_ready),
    .ext_imm(ext_imm), .busy(busy)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Cycle counter: the value seen during a cycle is that cycle's number
  always @(posedge clk) cyc++;

  task automatic check_output(input string name, input logic [DATA_W-1:0] act,
                              input logic [DATA_W-1:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, required %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic report_timeout(input string name);
    n_cmp++;
    n_fail++;
    $display("[TB] FAIL %s: wait bound expired at cycle %0d", name, cyc);
  endtask

  // Issue one request; when push is set the expected result is queued.
  task automatic apply_stimulus(input logic [IMM_W-1:0] i, input logic [1:0] op,
                                input logic [SHAMT_W-1:0] sh, input bit push,
                                input logic [DATA_W-1:0] expv);
    int   waited = 0;
    exp_t e;
    while (in_ready !== 1'b1 && waited < 200) begin
      @(posedge clk); #1;
      waited++;
    end
    if (in_ready !== 1'b1) report_timeout("in_ready_wait");
    imm      = i;
    ext_op   = op;
    shamt    = sh;
    in_valid = 1'b1;
    if (push) begin
      e.val = expv;
      e.cyc = cyc + 1 + (int'(sh) + STEP - 1) / STEP;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    imm      = 16'hDEAD;
    ext_op   = 2'b10;
    shamt    = 5'd7;
  endtask

  task automatic wait_idle();
    int w = 0;
    while ((exp_q.size() != 0 || busy !== 1'b0) && w < 200) begin
      @(posedge clk); #1;
      w++;
    end
    if (w >= 200) report_timeout("wait_idle");
  endtask

  // Monitor: pop on the first cycle of each result, then require stability while held
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (!holding) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("[TB] FAIL unexpected_out_valid: got ext_imm=%h at cycle %0d, required no output",
                   ext_imm, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          check_output("result", ext_imm, mon_e.val);
          check_output("latency", 32'(cyc), 32'(mon_e.cyc));
        end
        held    = ext_imm;
        holding = 1'b1;
      end else begin
        check_output("held_stable", ext_imm, held);
      end
      if (out_ready === 1'b1) holding = 1'b0;
    end else begin
      holding = 1'b0;
    end
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    report_timeout("global_watchdog");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Directed stimulus sequence
  initial begin
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_output("reset_out_valid", 32'(out_valid), 32'd0);
    check_output("reset_ext_imm", ext_imm, 32'd0);
    check_output("reset_busy", 32'(busy), 32'd0);
    check_output("reset_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Sign-extend a negative immediate, short shift
    apply_stimulus(16'h8001, 2'b01, 5'd2, 1'b1, 32'hFFFE0004);
    wait_idle();

    // Zero-extend, shift 16: busy for cycles A+1..A+5
    apply_stimulus(16'h1234, 2'b00, 5'd16, 1'b1, 32'h12340000);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_output("busy_during", 32'(busy), 32'd1);
    end
    @(negedge clk);
    check_output("busy_after", 32'(busy), 32'd0);
    @(posedge clk); #1;
    wait_idle();

    // Ones-extend, no shift
    apply_stimulus(16'h00FF, 2'b10, 5'd0, 1'b1, 32'hFFFF00FF);
    wait_idle();

    // Maximum shift, then the reserved op
    apply_stimulus(16'h0001, 2'b00, 5'd31, 1'b1, 32'h80000000);
    wait_idle();
    apply_stimulus(16'h0001, 2'b11, 5'd31, 1'b1, 32'h00000000);
    wait_idle();

    // Sign-extend a positive immediate, exactly one STEP
    apply_stimulus(16'h7FFF, 2'b01, 5'd4, 1'b1, 32'h0007FFF0);
    wait_idle();

    // Backpressure: three DONE cycles with out_ready low, then one handshake
    out_ready = 1'b0;
    apply_stimulus(16'h8001, 2'b01, 5'd2, 1'b1, 32'hFFFE0004);
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_output("bp_out_valid", 32'(out_valid), 32'd1);
      check_output("bp_ext_imm", ext_imm, 32'hFFFE0004);
      check_output("bp_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    check_output("bp_release_in_ready", 32'(in_ready), 32'd1);
    check_output("bp_release_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;

    // Flush in the second SHIFT cycle
    apply_stimulus(16'h0001, 2'b00, 5'd31, 1'b0, 32'h0);
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check_output("flush_busy", 32'(busy), 32'd0);
    check_output("flush_in_ready", 32'(in_ready), 32'd1);
    check_output("flush_ext_imm", ext_imm, 32'd0);

    // Flush together with in_valid: must not be accepted
    @(posedge clk); #1;
    flush    = 1'b1;
    in_valid = 1'b1;
    imm      = 16'h00FF;
    ext_op   = 2'b10;
    shamt    = 5'd0;
    @(posedge clk); #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check_output("flush_accept_busy", 32'(busy), 32'd0);
    repeat (12) @(posedge clk);
    #1;

    // Asynchronous reset in the middle of SHIFT
    apply_stimulus(16'hFFFF, 2'b01, 5'd31, 1'b0, 32'h0);
    @(posedge clk); #2;
    check_output("pre_reset_busy", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    check_output("async_reset_ext_imm", ext_imm, 32'd0);
    check_output("async_reset_busy", 32'(busy), 32'd0);
    check_output("async_reset_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Recovery after reset
    apply_stimulus(16'h8001, 2'b01, 5'd2, 1'b1, 32'hFFFE0004);
    wait_idle();
    repeat (3) @(posedge clk);
    check_output("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
